// File: rtl/line_filler_if.sv
// Memory burst-read bus between the line filler (master) and the memory controller (slave).
interface line_filler_if;
    logic        mem_rd_req;
    logic [23:0] mem_rd_addr;
    logic [8:0]  mem_rd_len;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        output mem_rd_len,
        input  mem_rd_ack,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        input  mem_rd_len,
        output mem_rd_ack,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/line_filler.sv
// Line filler: fetches one frame-buffer line in bursts and writes it into display line buffer A or B.
module line_filler #(
    parameter logic [23:0] FB_BASE    = 24'h000000,
    parameter int unsigned LINE_SHIFT = 10,
    parameter int unsigned BURST_LEN  = 256
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          vga_mode,
    input  logic          read_buffA_req,
    input  logic          read_buffB_req,
    input  logic [9:0]    read_buff_addr,
    line_filler_if.master mem,
    output logic [9:0]    buff_write_addr,
    output logic [15:0]   buff_write_data,
    output logic          buff_writeA_en,
    output logic          buff_writeB_en,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {StIdle, StIssue, StData} state_t;

    state_t      r_state, r_state_d;

    logic [1:0]  r_a_sync, r_b_sync;
    logic        r_a_prev, r_b_prev;
    logic        r_a_arm, r_b_arm;
    logic [1:0]  r_sync_vld;

    logic        r_buf, r_buf_d;          // 0 = buffer A, 1 = buffer B
    logic [9:0]  r_line, r_line_d;
    logic        r_n1024, r_n1024_d;
    logic [10:0] r_p, r_p_d;              // pixels already requested
    logic [9:0]  r_wcnt, r_wcnt_d;
    logic [8:0]  r_bcnt, r_bcnt_d;        // words received in current burst
    logic        r_pend, r_pend_d;
    logic        r_pend_buf, r_pend_buf_d;
    logic [9:0]  r_pend_line, r_pend_line_d;
    logic        r_pend_n1024, r_pend_n1024_d;
    logic        r_overrun, r_overrun_d;

    logic        w_ev_a, w_ev_b, w_ev_any;
    logic [10:0] w_n, w_rem;
    logic [8:0]  w_len;
    logic        w_wr, w_burst_done, w_line_done;
    logic [23:0] w_base;

    // Two-flop synchronizers plus edge detect; an edge only counts once a genuine low was seen
    // after reset, so a request held high across reset release stays silent.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a_sync   <= 2'b00;
            r_b_sync   <= 2'b00;
            r_a_prev   <= 1'b0;
            r_b_prev   <= 1'b0;
            r_a_arm    <= 1'b0;
            r_b_arm    <= 1'b0;
            r_sync_vld <= 2'b00;
        end else begin
            r_a_sync   <= {r_a_sync[0], read_buffA_req};
            r_b_sync   <= {r_b_sync[0], read_buffB_req};
            r_a_prev   <= r_a_sync[1];
            r_b_prev   <= r_b_sync[1];
            r_a_arm    <= r_a_arm | (r_sync_vld[1] & ~r_a_sync[1]);
            r_b_arm    <= r_b_arm | (r_sync_vld[1] & ~r_b_sync[1]);
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    assign w_ev_a   = r_a_sync[1] & ~r_a_prev & r_a_arm;
    assign w_ev_b   = r_b_sync[1] & ~r_b_prev & r_b_arm;
    assign w_ev_any = w_ev_a | w_ev_b;

    assign w_n          = r_n1024 ? 11'd1024 : 11'd640;
    assign w_rem        = w_n - r_p;
    assign w_len        = (w_rem > 11'(BURST_LEN)) ? 9'(BURST_LEN) : w_rem[8:0];
    assign w_base       = FB_BASE + (24'(r_line) << LINE_SHIFT) + 24'(r_p);
    assign w_wr         = (r_state == StData) & mem.mem_rd_valid;
    assign w_burst_done = w_wr & (r_bcnt == w_len - 9'd1);
    assign w_line_done  = ((r_p + {2'b00, w_len}) >= w_n);

    // Outputs are forced to zero outside the phase that owns them.
    assign mem.mem_rd_req  = (r_state == StIssue);
    assign mem.mem_rd_addr = (r_state == StIssue) ? w_base : 24'd0;
    assign mem.mem_rd_len  = (r_state == StIssue) ? w_len : 9'd0;
    assign buff_write_addr = w_wr ? r_wcnt : 10'd0;
    assign buff_write_data = w_wr ? mem.mem_rd_data : 16'd0;
    assign buff_writeA_en  = w_wr & ~r_buf;
    assign buff_writeB_en  = w_wr & r_buf;
    assign busy            = (r_state != StIdle);
    assign overrun         = r_overrun;

    // Next-state: request capture, pending/overrun bookkeeping and burst sequencing.
    always_comb begin
        r_state_d      = r_state;
        r_buf_d        = r_buf;
        r_line_d       = r_line;
        r_n1024_d      = r_n1024;
        r_p_d          = r_p;
        r_wcnt_d       = r_wcnt;
        r_bcnt_d       = r_bcnt;
        r_pend_d       = r_pend;
        r_pend_buf_d   = r_pend_buf;
        r_pend_line_d  = r_pend_line;
        r_pend_n1024_d = r_pend_n1024;
        r_overrun_d    = r_overrun;

        // A request while busy replaces any earlier pending one; A wins a same-cycle tie.
        if (busy && w_ev_any) begin
            r_pend_d       = 1'b1;
            r_pend_buf_d   = ~w_ev_a;
            r_pend_line_d  = read_buff_addr;
            r_pend_n1024_d = vga_mode;
            r_overrun_d    = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (w_ev_any) begin
                    r_state_d = StIssue;
                    r_buf_d   = ~w_ev_a;
                    r_line_d  = read_buff_addr;
                    r_n1024_d = vga_mode;
                    r_p_d     = 11'd0;
                    r_wcnt_d  = 10'd0;
                    r_bcnt_d  = 9'd0;
                    // Simultaneous A and B: B waits behind A.
                    if (w_ev_a && w_ev_b) begin
                        r_pend_d       = 1'b1;
                        r_pend_buf_d   = 1'b1;
                        r_pend_line_d  = read_buff_addr;
                        r_pend_n1024_d = vga_mode;
                        r_overrun_d    = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (mem.mem_rd_ack) begin
                    r_state_d = StData;
                    r_bcnt_d  = 9'd0;
                end
            end
            StData: begin
                if (w_wr) begin
                    r_wcnt_d = r_wcnt + 10'd1;
                    r_bcnt_d = r_bcnt + 9'd1;
                end
                if (w_burst_done) begin
                    r_bcnt_d = 9'd0;
                    if (r_pend_d) begin
                        // Abandon the rest of this line and go straight to the queued one.
                        r_state_d = StIssue;
                        r_buf_d   = r_pend_buf_d;
                        r_line_d  = r_pend_line_d;
                        r_n1024_d = r_pend_n1024_d;
                        r_p_d     = 11'd0;
                        r_wcnt_d  = 10'd0;
                        r_pend_d  = 1'b0;
                    end else if (w_line_done) begin
                        r_state_d = StIdle;
                    end else begin
                        r_state_d = StIssue;
                        r_p_d     = r_p + {2'b00, w_len};
                    end
                end
            end
            default: r_state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= StIdle;
        else            r_state <= r_state_d;
    end

    // Fill context, counters, pending request and sticky overrun.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_buf        <= 1'b0;
            r_line       <= 10'd0;
            r_n1024      <= 1'b0;
            r_p          <= 11'd0;
            r_wcnt       <= 10'd0;
            r_bcnt       <= 9'd0;
            r_pend       <= 1'b0;
            r_pend_buf   <= 1'b0;
            r_pend_line  <= 10'd0;
            r_pend_n1024 <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_buf        <= r_buf_d;
            r_line       <= r_line_d;
            r_n1024      <= r_n1024_d;
            r_p          <= r_p_d;
            r_wcnt       <= r_wcnt_d;
            r_bcnt       <= r_bcnt_d;
            r_pend       <= r_pend_d;
            r_pend_buf   <= r_pend_buf_d;
            r_pend_line  <= r_pend_line_d;
            r_pend_n1024 <= r_pend_n1024_d;
            r_overrun    <= r_overrun_d;
        end
    end

endmodule

// File: tb/tb_line_filler.sv
// Scoreboard bench for line_filler: a memory model answers bursts, a line-level reference
// model queues the expected bursts and pixel writes, and a monitor pops and compares them.
module tb_line_filler;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        vga_mode;
    logic        a_req, b_req;
    logic [9:0]  rb_addr;
    logic [9:0]  buff_write_addr;
    logic [15:0] buff_write_data;
    logic        buff_writeA_en, buff_writeB_en;
    logic        busy, overrun;

    line_filler_if ifc ();

    line_filler dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .vga_mode        (vga_mode),
        .read_buffA_req  (a_req),
        .read_buffB_req  (b_req),
        .read_buff_addr  (rb_addr),
        .mem             (ifc),
        .buff_write_addr (buff_write_addr),
        .buff_write_data (buff_write_data),
        .buff_writeA_en  (buff_writeA_en),
        .buff_writeB_en  (buff_writeB_en),
        .busy            (busy),
        .overrun         (overrun)
    );

    initial forever #5 sys_clk = ~sys_clk;

    typedef struct { logic [23:0] addr; logic [8:0] len; } burst_t;
    typedef struct { logic b; logic [9:0] idx; logic [15:0] data; } wr_t;

    burst_t q_b[$];
    wr_t    q_w[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     n_wr = 0;
    int     ack_dly = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], 8'h3c};
    endfunction

    // Reference: a line is N pixels fetched in bursts of at most 256 from base + L*1024 + P;
    // pixel P+i lands at line-buffer index P+i. max_b cuts the line short (abandonment).
    task automatic expect_line(input logic b, input int l, input logic m, input int max_b);
        int n;
        int p;
        int k;
        n = m ? 1024 : 640;
        p = 0;
        k = 0;
        while (p < n && k < max_b) begin
            int len;
            logic [23:0] a;
            len = (n - p > 256) ? 256 : n - p;
            a = 24'((l * 1024 + p) % (1 << 24));
            q_b.push_back('{addr: a, len: 9'(len)});
            for (int i = 0; i < len; i++)
                q_w.push_back('{b: b, idx: 10'(p + i), data: mem_word(a + 24'(i))});
            p += len;
            k++;
        end
    endtask

    task automatic pulse(input logic do_a, input logic do_b);
        @(negedge sys_clk);
        if (do_a) a_req = 1'b1;
        if (do_b) b_req = 1'b1;
        repeat (4) @(negedge sys_clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while ((q_b.size() != 0 || q_w.size() != 0 || busy) && c < budget) begin
            @(negedge sys_clk);
            #1;
            c++;
        end
        n_chk++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: bursts left %0d writes left %0d busy %0b, required all drained",
                     name, q_b.size(), q_w.size(), busy);
            q_b.delete();
            q_w.delete();
        end
        repeat (3) @(negedge sys_clk);
    endtask

    // Memory slave: ack after ack_dly cycles, then len words with random gaps.
    initial begin : mem_model
        logic [23:0] a;
        logic [8:0]  l;
        logic        ok;
        ifc.mem_rd_ack   = 1'b0;
        ifc.mem_rd_valid = 1'b0;
        ifc.mem_rd_data  = 16'd0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && ifc.mem_rd_req) begin
                a  = ifc.mem_rd_addr;
                l  = ifc.mem_rd_len;
                ok = 1'b1;
                for (int i = 0; i < ack_dly; i++) begin
                    @(negedge sys_clk);
                    if (!sys_rst_n) begin
                        ok = 1'b0;
                        break;
                    end
                    chk("hold_req", 32'(ifc.mem_rd_req), 32'd1);
                    chk("hold_addr", 32'(ifc.mem_rd_addr), 32'(a));
                    chk("hold_len", 32'(ifc.mem_rd_len), 32'(l));
                    chk("early_write", 32'({buff_writeA_en, buff_writeB_en}), 32'd0);
                end
                if (ok) begin
                    ifc.mem_rd_ack = 1'b1;
                    @(negedge sys_clk);
                    ifc.mem_rd_ack = 1'b0;
                    if (!sys_rst_n) ok = 1'b0;
                    else chk("req_drop", 32'(ifc.mem_rd_req), 32'd0);
                end
                for (int i = 0; ok && i < int'(l); i++) begin
                    while (sys_rst_n && $urandom_range(3) == 0) @(negedge sys_clk);
                    if (!sys_rst_n) begin
                        ok = 1'b0;
                        break;
                    end
                    ifc.mem_rd_valid = 1'b1;
                    ifc.mem_rd_data  = mem_word(a + 24'(i));
                    @(negedge sys_clk);
                    ifc.mem_rd_valid = 1'b0;
                end
                ifc.mem_rd_ack   = 1'b0;
                ifc.mem_rd_valid = 1'b0;
            end
        end
    end

    // Monitor: compares every accepted burst and every pixel write against the queues.
    initial begin : monitor
        burst_t eb;
        wr_t    ew;
        forever begin
            @(negedge sys_clk);
            #1;
            if (buff_writeA_en && buff_writeB_en) chk("both_en", 32'd1, 32'd0);
            if (ifc.mem_rd_req && ifc.mem_rd_ack) begin
                if (q_b.size() == 0) begin
                    chk("unexpected_burst", 32'(ifc.mem_rd_addr), 32'hffffffff);
                end else begin
                    eb = q_b.pop_front();
                    chk("burst_addr", 32'(ifc.mem_rd_addr), 32'(eb.addr));
                    chk("burst_len", 32'(ifc.mem_rd_len), 32'(eb.len));
                end
            end
            if (buff_writeA_en || buff_writeB_en) begin
                n_wr++;
                if (q_w.size() == 0) begin
                    chk("unexpected_write", 32'(buff_write_addr), 32'hffffffff);
                end else begin
                    ew = q_w.pop_front();
                    chk("wr_buf_b", 32'(buff_writeB_en), 32'(ew.b));
                    chk("wr_addr", 32'(buff_write_addr), 32'(ew.idx));
                    chk("wr_data", 32'(buff_write_data), 32'(ew.data));
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_req"}, 32'(ifc.mem_rd_req), 32'd0);
        chk({name, "_addr"}, 32'(ifc.mem_rd_addr), 32'd0);
        chk({name, "_len"}, 32'(ifc.mem_rd_len), 32'd0);
        chk({name, "_wen"}, 32'({buff_writeA_en, buff_writeB_en}), 32'd0);
        chk({name, "_waddr"}, 32'(buff_write_addr), 32'd0);
        chk({name, "_wdata"}, 32'(buff_write_data), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin : stim
        int la, lb, base, c;
        logic m, bsel;
        sys_rst_n = 1'b0;
        a_req     = 1'b0;
        b_req     = 1'b0;
        vga_mode  = 1'b0;
        rb_addr   = 10'd0;
        repeat (5) @(negedge sys_clk);
        #1;
        chk_all_zero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Basic 640 fill into A, line 5.
        vga_mode = 1'b0;
        rb_addr  = 10'd5;
        ack_dly  = 0;
        expect_line(1'b0, 5, 1'b0, 99);
        pulse(1'b1, 1'b0);
        #1;
        chk("busy_during_fill", 32'(busy), 32'd1);
        wait_done("s1", 4000);
        chk("s1_busy_low", 32'(busy), 32'd0);

        // 1024 fill into B, line 767.
        vga_mode = 1'b1;
        rb_addr  = 10'd767;
        expect_line(1'b1, 767, 1'b1, 99);
        pulse(1'b0, 1'b1);
        wait_done("s2", 6000);

        // Slow ack on every burst.
        vga_mode = 1'b0;
        rb_addr  = 10'd321;
        ack_dly  = 10;
        expect_line(1'b0, 321, 1'b0, 99);
        pulse(1'b1, 1'b0);
        wait_done("s3", 6000);

        // Randomised non-overlapping fills.
        for (int k = 0; k < 6; k++) begin
            bsel     = 1'($urandom_range(1));
            m        = 1'($urandom_range(1));
            la       = int'($urandom_range(1023));
            ack_dly  = int'($urandom_range(12));
            vga_mode = m;
            rb_addr  = 10'(la);
            expect_line(bsel, la, m, 99);
            pulse(~bsel, bsel);
            wait_done("rand", 6000);
        end
        chk("no_overrun_yet", 32'(overrun), 32'd0);

        // Overrun: B request lands while A's first burst is still waiting for ack.
        la       = int'($urandom_range(1023));
        lb       = int'($urandom_range(1023));
        ack_dly  = 10;
        vga_mode = 1'b0;
        rb_addr  = 10'(la);
        expect_line(1'b0, la, 1'b0, 1);
        expect_line(1'b1, lb, 1'b1, 99);
        pulse(1'b1, 1'b0);
        vga_mode = 1'b1;
        rb_addr  = 10'(lb);
        pulse(1'b0, 1'b1);
        wait_done("s4", 8000);
        chk("s4_overrun", 32'(overrun), 32'd1);

        // Simultaneous A and B.
        la       = int'($urandom_range(1023));
        ack_dly  = int'($urandom_range(5));
        vga_mode = 1'b0;
        rb_addr  = 10'(la);
        expect_line(1'b0, la, 1'b0, 1);
        expect_line(1'b1, la, 1'b0, 99);
        pulse(1'b1, 1'b1);
        wait_done("s5", 6000);
        chk("s5_overrun", 32'(overrun), 32'd1);

        // Reset after 100 words, with A held high across release.
        la       = int'($urandom_range(1023));
        ack_dly  = 0;
        vga_mode = 1'b1;
        rb_addr  = 10'(la);
        base     = n_wr;
        expect_line(1'b0, la, 1'b1, 99);
        pulse(1'b1, 1'b0);
        c = 0;
        while (n_wr < base + 100 && c < 3000) begin
            @(negedge sys_clk);
            c++;
        end
        chk("s6_reach_100_timeout", 32'(c >= 3000), 32'd0);
        sys_rst_n = 1'b0;
        a_req     = 1'b1;
        #1;
        chk_all_zero("s6_in_reset");
        q_b.delete();
        q_w.delete();
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        #1;
        chk("s6_held_req_busy", 32'(busy), 32'd0);
        chk("s6_held_req_mem", 32'(ifc.mem_rd_req), 32'd0);
        chk("s6_overrun_cleared", 32'(overrun), 32'd0);
        a_req = 1'b0;
        repeat (5) @(negedge sys_clk);
        la       = int'($urandom_range(1023));
        vga_mode = 1'b0;
        rb_addr  = 10'(la);
        expect_line(1'b0, la, 1'b0, 99);
        pulse(1'b1, 1'b0);
        wait_done("s6_restart", 4000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
